// File: rtl/data_ram_pkg.sv
// -----------------------------------------------------------------------------
// data_ram_pkg
// Shared definitions for the data memory block: bus width, common constants
// and the state encoding of the optional zero-fill sequencer.
// Optional feature macro used by the block: DATA_RAM_ZERO_FILL_EN.
// -----------------------------------------------------------------------------
package data_ram_pkg;

    localparam int          InstBus  = 32;
    localparam logic [31:0] ZeroWord = 32'h0000_0000;
    localparam logic        Enable   = 1'b1;
    localparam logic        Disable  = 1'b0;

    // Zero-fill sequencer states: CLEAR sweeps the array, RUN serves accesses.
    typedef enum logic {
        RAM_CLEAR = 1'b0,
        RAM_RUN   = 1'b1
    } ram_state_e;

endpackage

// File: rtl/data_ram_if.sv
// -----------------------------------------------------------------------------
// data_ram_if
// Load/store bus between the core (master) and the data memory (slave).
//   addr     : byte address, bits [1:0] ignored by the memory
//   w_data   : lane-aligned write data
//   wen      : byte-lane write enables
//   ren      : read request
//   err_clr  : clears the pending-fault flag
//   r_data   : registered read data (1-cycle latency)
//   ready    : memory accepts accesses
//   err      : one-cycle out-of-range pulse
//   err_addr : address of the first captured fault
// -----------------------------------------------------------------------------
interface data_ram_if;
    import data_ram_pkg::*;

    logic [InstBus-1:0] addr;
    logic [InstBus-1:0] w_data;
    logic [3:0]         wen;
    logic               ren;
    logic               err_clr;
    logic [InstBus-1:0] r_data;
    logic               ready;
    logic               err;
    logic [InstBus-1:0] err_addr;

    modport master (
        output addr, w_data, wen, ren, err_clr,
        input  r_data, ready, err, err_addr
    );

    modport slave (
        input  addr, w_data, wen, ren, err_clr,
        output r_data, ready, err, err_addr
    );

endinterface

// File: rtl/data_ram_ram_array.sv
// -----------------------------------------------------------------------------
// ram_array
// 2^DEPTH_LOG2 x 32-bit storage with per-byte write enables and one
// synchronous read port. The read register can be forced to zero instead of
// loading from the array (used for out-of-range reads).
//   clk, rst    : clock, synchronous active-high reset (read register only)
//   we_i        : byte-lane write enables
//   waddr_i     : write word index
//   wdata_i     : write data
//   re_i        : load the read register from raddr_i
//   rd_zero_i   : load the read register with zero (has priority over re_i)
//   raddr_i     : read word index
//   rdata_o     : registered read data
// -----------------------------------------------------------------------------
module ram_array
    import data_ram_pkg::*;
#(
    parameter int DEPTH_LOG2 = 12
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [3:0]            we_i,
    input  logic [DEPTH_LOG2-1:0] waddr_i,
    input  logic [InstBus-1:0]    wdata_i,
    input  logic                  re_i,
    input  logic                  rd_zero_i,
    input  logic [DEPTH_LOG2-1:0] raddr_i,
    output logic [InstBus-1:0]    rdata_o
);

    logic [InstBus-1:0] mem_q [0:(1<<DEPTH_LOG2)-1];
    logic [InstBus-1:0] rdata_q;

    // Byte-lane writes; storage is deliberately not reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (we_i[i]) begin
                mem_q[waddr_i][8*i +: 8] <= wdata_i[8*i +: 8];
            end
        end
    end

    // Read register: non-blocking update gives read-before-write on a shared word.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q <= ZeroWord;
        end else if (rd_zero_i) begin
            rdata_q <= ZeroWord;
        end else if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end else begin
            rdata_q <= rdata_q;
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/data_ram.sv
// -----------------------------------------------------------------------------
// data_ram
// Word-organised data memory for the load/store path. Decodes the byte
// address against the [BASE_ADDR, BASE_ADDR + 4*2^DEPTH_LOG2) window,
// performs byte-lane writes, returns read data one cycle after the request
// and records out-of-range accesses in a sticky fault register.
//   clk   : clock
//   rst   : synchronous active-high reset
//   bus   : data_ram_if slave modport (addr/w_data/wen/ren/err_clr in,
//           r_data/ready/err/err_addr out)
// Optional feature: define DATA_RAM_ZERO_FILL_EN to zero the whole array
// after every reset; ready stays low until the sweep finishes. Without it,
// ready is tied high and array contents power up undefined.
// -----------------------------------------------------------------------------
module data_ram
    import data_ram_pkg::*;
#(
    parameter int                 DEPTH_LOG2 = 12,
    parameter logic [InstBus-1:0] BASE_ADDR  = 32'h0000_0000
) (
    input  logic       clk,
    input  logic       rst,
    data_ram_if.slave  bus
);

    localparam logic [InstBus:0] MemBytes = 33'd4 << DEPTH_LOG2;

    logic [InstBus-1:0]    off_s;
    logic                  in_range_s;
    logic [DEPTH_LOG2-1:0] idx_s;
    logic                  access_s;
    logic                  fault_s;
    logic                  ready_s;
    logic                  fill_s;
    logic [DEPTH_LOG2-1:0] clr_idx_s;

    logic [3:0]            ram_we_s;
    logic [DEPTH_LOG2-1:0] ram_waddr_s;
    logic [InstBus-1:0]    ram_wdata_s;
    logic [InstBus-1:0]    ram_rdata_s;

    logic                  err_q,      err_d;
    logic                  err_pend_q, err_pend_d;
    logic [InstBus-1:0]    err_addr_q, err_addr_d;

    // Address decode: offset wraps modulo 2^32, so addresses below BASE_ADDR land out of range.
    always_comb begin
        off_s      = bus.addr - BASE_ADDR;
        in_range_s = ({1'b0, off_s} < MemBytes);
        idx_s      = off_s[DEPTH_LOG2+1:2];
        access_s   = ready_s && (bus.ren || (bus.wen != 4'b0000));
        fault_s    = access_s && !in_range_s;
    end

`ifdef DATA_RAM_ZERO_FILL_EN
    localparam logic [DEPTH_LOG2-1:0] LastIdx = {DEPTH_LOG2{1'b1}};
    localparam logic [DEPTH_LOG2-1:0] OneIdx  = {{(DEPTH_LOG2-1){1'b0}}, 1'b1};

    ram_state_e            state_q, state_d;
    logic [DEPTH_LOG2-1:0] clr_idx_q, clr_idx_d;

    // Zero-fill sequencer state register; reset restarts the sweep at word 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= RAM_CLEAR;
            clr_idx_q <= {DEPTH_LOG2{1'b0}};
        end else begin
            state_q   <= state_d;
            clr_idx_q <= clr_idx_d;
        end
    end

    // Zero-fill next state: leave CLEAR once the last word has been written.
    always_comb begin
        state_d   = state_q;
        clr_idx_d = clr_idx_q;
        case (state_q)
            RAM_CLEAR: begin
                clr_idx_d = clr_idx_q + OneIdx;
                if (clr_idx_q == LastIdx) begin
                    state_d = RAM_RUN;
                end else begin
                    state_d = RAM_CLEAR;
                end
            end
            RAM_RUN: begin
                state_d = RAM_RUN;
            end
            default: begin
                state_d   = RAM_CLEAR;
                clr_idx_d = {DEPTH_LOG2{1'b0}};
            end
        endcase
    end

    // Zero-fill outputs: accesses are accepted only in RUN.
    always_comb begin
        ready_s   = Disable;
        fill_s    = Disable;
        clr_idx_s = clr_idx_q;
        case (state_q)
            RAM_CLEAR: begin
                ready_s = Disable;
                fill_s  = Enable;
            end
            RAM_RUN: begin
                ready_s = Enable;
                fill_s  = Disable;
            end
            default: begin
                ready_s = Disable;
                fill_s  = Disable;
            end
        endcase
    end
`else
    assign ready_s   = Enable;
    assign fill_s    = Disable;
    assign clr_idx_s = {DEPTH_LOG2{1'b0}};
`endif

    // Write-port steering: the zero-fill sweep owns the port while it runs.
    always_comb begin
        ram_we_s    = 4'b0000;
        ram_waddr_s = idx_s;
        ram_wdata_s = bus.w_data;
        if (fill_s) begin
            ram_we_s    = 4'b1111;
            ram_waddr_s = clr_idx_s;
            ram_wdata_s = ZeroWord;
        end else if (ready_s && in_range_s) begin
            ram_we_s = bus.wen;
        end else begin
            ram_we_s = 4'b0000;
        end
    end

    ram_array #(
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_ram_array (
        .clk       (clk),
        .rst       (rst),
        .we_i      (ram_we_s),
        .waddr_i   (ram_waddr_s),
        .wdata_i   (ram_wdata_s),
        .re_i      (ready_s && bus.ren && in_range_s),
        .rd_zero_i (ready_s && bus.ren && !in_range_s),
        .raddr_i   (idx_s),
        .rdata_o   (ram_rdata_s)
    );

    // Fault capture: a fault on the same edge as err_clr still wins the capture.
    always_comb begin
        err_d      = fault_s;
        err_pend_d = err_pend_q;
        err_addr_d = err_addr_q;
        if (fault_s && (!err_pend_q || bus.err_clr)) begin
            err_pend_d = Enable;
            err_addr_d = bus.addr;
        end else if (bus.err_clr) begin
            err_pend_d = Disable;
        end else begin
            err_pend_d = err_pend_q;
        end
    end

    // Fault register state.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_q      <= Disable;
            err_pend_q <= Disable;
            err_addr_q <= ZeroWord;
        end else begin
            err_q      <= err_d;
            err_pend_q <= err_pend_d;
            err_addr_q <= err_addr_d;
        end
    end

    assign bus.r_data   = ram_rdata_s;
    assign bus.ready    = ready_s;
    assign bus.err      = err_q;
    assign bus.err_addr = err_addr_q;

endmodule

// File: doc/data_ram.md
# data_ram

Word-organised data memory that sits on the memory side of the load/store path. It answers the `addr`/`ren`/`wen`/`w_data` requests driven by the core's load/store interface and returns `r_data` with exactly one cycle of read latency, which is the latency that interface stalls for. It performs byte-lane writes and range-checks every address against its window. It also records out-of-range accesses in a sticky fault register.

## Interface
- `DEPTH_LOG2`, default 12: memory depth is 2^DEPTH_LOG2 32-bit words.
- `BASE_ADDR`, default 32'h0000_0000: byte address of word 0. Must be word-aligned.
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst`  in  1: reset is synchronous and active-high.
- `addr`  in  32: byte address; bits [1:0] are ignored because the initiator aligns lanes.
- `w_data`  in  32: write data, already lane-aligned.
- `wen`  in  4: byte-lane write enables; bit i covers `w_data[8i+7:8i]`.
- `ren`  in  1: read request.
- `r_data`  out  32: registered read data.
- `ready`  out  1: memory is accepting accesses.
- `err`  out  1: one-cycle pulse flagging an out-of-range access.
- `err_addr`  out  32: byte address of the first fault since reset or since the last clear.
- `err_clr`  in  1: clears the pending-fault flag.

## Operation
- Address decode:
  - `off = addr - BASE_ADDR` (32-bit, wraps modulo 2^32).
  - The access is in range iff `off < 4*2^DEPTH_LOG2`.
  - Word index is `off[DEPTH_LOG2+1:2]`.
- An access is accepted only on an edge where `ready=1`. When `ready=0`, requests are ignored: no write, `r_data` unchanged, no `err`.
- Write, when accepted, in range and `wen != 0`:
  - Each lane with `wen[i]=1` is replaced.
  - Lanes with `wen[i]=0` keep their old value.
- Read, when accepted with `ren=1`:
  - In range: `r_data <= mem[idx]`.
  - When `ren=0`, `r_data` holds its last value.
- Read and write on the same edge:
  - Both are performed.
  - Same word: read-before-write, so `r_data` gets the old word.
- Out-of-range access (accepted, and `ren=1` or `wen != 0`):
  - Write is dropped.
  - A read loads `r_data <= 0`.
  - `err` pulses high on the next cycle.
- Fault capture:
  - Internal flag `err_pend`.
  - On a fault with `err_pend=0`: `err_addr <= addr`, `err_pend <= 1`.
  - Later faults pulse `err` but do not overwrite `err_addr`.
  - `err_clr` clears `err_pend`. If `err_clr` and a fault occur on the same edge, the new fault is captured and `err_pend` stays 1.
- Reset values: `r_data=0`, `err=0`, `err_addr=0`, `err_pend=0`. `ready` is as specified under Configuration.
- Memory contents are never affected by `rst` except as specified under Configuration.

## Timing
- Read latency is 1: a request sampled at edge N gives valid `r_data` after edge N; the core consumes it in cycle N+1.
- A write at edge N is visible to a read sampled at edge N+1.
- Back-to-back reads: one per cycle, no bubbles.
- `err` is high for exactly the cycle after each faulting edge. Consecutive faulting accesses keep it high continuously.

## Configuration
- Macro: `DATA_RAM_ZERO_FILL_EN`.
- Defined:
  - Two-state FSM, CLEAR and RUN.
  - `rst` forces CLEAR with `clr_idx=0` and `ready=0`.
  - In CLEAR, each cycle writes 0 to `mem[clr_idx]` and increments `clr_idx`.
  - When `clr_idx = 2^DEPTH_LOG2-1` is written, the FSM moves to RUN next edge; `ready=1` in RUN.
  - `ready` rises exactly 2^DEPTH_LOG2 cycles after `rst` deasserts.
  - `rst` during CLEAR restarts at index 0.
- Not defined:
  - No FSM and no counter; `ready` is constant 1, including during reset.
  - Memory power-up contents are undefined.

## Structure
- Shared defines file holds:
  - `InstBus` width, `ZeroWord`, `Enable`/`Disable`.
  - New `RAM_CLEAR`/`RAM_RUN` state encodings.
- One sub-module, `ram_array`: 2^DEPTH_LOG2 x 32 storage with 4 byte-lane write enables and a synchronous read port.
- `data_ram` holds the decode, range check, zero-fill FSM and fault register.

## Test plan
- No macro, DEPTH_LOG2=4:
  - Write `wen=4'b1111`, addr 0x10, data 0xDEADBEEF.
  - Next cycle `ren` at 0x10 -> `r_data=0xDEADBEEF` one cycle later.
- Lane write: `wen=4'b0100`, addr 0x12, `w_data=0x00AA0000`, then read 0x10 -> 0xDEAABEEF.
- Same-edge read and write to 0x10 with new data 0x11111111:
  - `r_data` = old word.
  - The following read gives 0x11111111.
  - `ren=0` for 3 cycles -> `r_data` stable.
- Fault sequence:
  - Read 0x40 -> `r_data=0`, `err` pulses once, `err_addr=0x40`.
  - Write 0x44 -> `err` pulses, `err_addr` still 0x40, memory unchanged.
  - `err_clr`, then read 0x48 -> `err_addr=0x48`.
- Macro defined, DEPTH_LOG2=4:
  - Fill memory, then `rst` -> `ready=0` for 16 cycles, then 1; all reads return 0.
  - A write while `ready=0` is ignored.
- Macro defined: `rst` reasserted at cycle 5 of CLEAR -> `ready` rises 16 cycles after the second release.
